// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART_TX-side signal bundle for uart_tx_arbiter.
// The arbiter takes the slave modport. The requester/UART_TX side takes the master modport.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   i_Req_DV;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   i_Req_Last;
  logic [NUM_REQ-1:0]   o_Req_Ack;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active;
  logic                 i_TX_Done;
  logic                 o_Busy;

  modport slave (
    input  i_Req_DV, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
    output o_Req_Ack, o_Grant, o_TX_DV, o_TX_Byte, o_Busy
  );

  modport master (
    output i_Req_DV, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
    input  o_Req_Ack, o_Grant, o_TX_DV, o_TX_Byte, o_Busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART_TX among NUM_REQ byte sources.
// A grant is held until the packet's last byte, the burst limit, or a gap timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned GAP_CLKS  = 4096
) (
  input logic              i_Clk,
  input logic              i_Rst_L,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned BURST_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam int unsigned GAP_W   = $clog2(GAP_CLKS + 1);
  localparam int unsigned BURST_SAT = (MAX_BURST == 0) ? 1 : MAX_BURST;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t               r_state,     w_state;
  logic [IDX_W-1:0]     r_ptr,       w_ptr;
  logic [IDX_W-1:0]     r_owner,     w_owner;
  logic [NUM_REQ-1:0]   r_grant,     w_grant;
  logic [NUM_REQ-1:0]   r_ack,       w_ack;
  logic                 r_tx_dv,     w_tx_dv;
  logic [7:0]           r_tx_byte,   w_tx_byte;
  logic                 r_busy,      w_busy;
  logic                 r_last,      w_last;
  logic [BURST_W-1:0]   r_burst_cnt, w_burst_cnt;
  logic [GAP_W-1:0]     r_gap_cnt,   w_gap_cnt;

  logic                 w_owner_dv;
  logic                 w_owner_last;
  logic [7:0]           w_owner_byte;
  logic [IDX_W:0]       w_pick;
  logic [IDX_W-1:0]     w_next_ptr;
  logic                 w_burst_hit;
  logic                 w_tx_idle;
  logic                 w_release;

  // First requesting index at or after ptr, with wrap; MSB flags a hit.
  function automatic logic [IDX_W:0] pick_next(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] res;
    int unsigned    idx;
    res = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      idx = (32'(ptr) + i - 1) % NUM_REQ;
      if (req[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  assign w_owner_dv   = bus.i_Req_DV[r_owner];
  assign w_owner_last = bus.i_Req_Last[r_owner];
  assign w_owner_byte = bus.i_Req_Byte[{r_owner, 3'b000} +: 8];
  assign w_pick       = pick_next(bus.i_Req_DV, r_ptr);
  assign w_next_ptr   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
  assign w_burst_hit  = (MAX_BURST != 0) && (r_burst_cnt == BURST_W'(MAX_BURST));
  assign w_tx_idle    = !bus.i_TX_Active && !bus.i_TX_Done;

  // Next-state and next-output logic
  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_owner     = r_owner;
    w_grant     = r_grant;
    w_ack       = '0;
    w_tx_dv     = 1'b0;
    w_tx_byte   = r_tx_byte;
    w_last      = r_last;
    w_burst_cnt = r_burst_cnt;
    w_gap_cnt   = r_gap_cnt;
    w_release   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_pick[IDX_W]) begin
          w_owner     = w_pick[IDX_W-1:0];
          w_grant     = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick[IDX_W-1:0];
          w_burst_cnt = '0;
          w_gap_cnt   = '0;
          w_state     = S_SEND;
        end
      end
      S_SEND: begin
        if (w_owner_dv) begin
          // Issue only when UART_TX is neither shifting nor in its Done cleanup.
          if (w_tx_idle) begin
            w_tx_byte = w_owner_byte;
            w_tx_dv   = 1'b1;
            w_ack     = r_grant;
            w_last    = w_owner_last;
            if (r_burst_cnt != BURST_W'(BURST_SAT)) w_burst_cnt = r_burst_cnt + BURST_W'(1);
            w_gap_cnt = '0;
            w_state   = S_WAIT_DONE;
          end
        end else if (r_gap_cnt >= GAP_W'(GAP_CLKS - 1)) begin
          w_release = 1'b1;
        end else begin
          w_gap_cnt = r_gap_cnt + GAP_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (bus.i_TX_Done) begin
          if (r_last || w_burst_hit) w_release = 1'b1;
          else                       w_state   = S_SEND;
        end
      end
      default: w_state = S_IDLE;
    endcase

    if (w_release) begin
      w_ptr   = w_next_ptr;
      w_grant = '0;
      w_state = S_IDLE;
    end

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_busy      <= 1'b0;
      r_last      <= 1'b0;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_owner     <= w_owner;
      r_grant     <= w_grant;
      r_ack       <= w_ack;
      r_tx_dv     <= w_tx_dv;
      r_tx_byte   <= w_tx_byte;
      r_busy      <= w_busy;
      r_last      <= w_last;
      r_burst_cnt <= w_burst_cnt;
      r_gap_cnt   <= w_gap_cnt;
    end
  end

  assign bus.o_Req_Ack = r_ack;
  assign bus.o_Grant   = r_grant;
  assign bus.o_TX_DV   = r_tx_dv;
  assign bus.o_TX_Byte = r_tx_byte;
  assign bus.o_Busy    = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART_TX (CLKS_PER_BIT=4).
// Instance A: MAX_BURST=16, GAP_CLKS=8. Instance B: MAX_BURST=2.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(2)) ifa ();
  uart_tx_arbiter_if #(.NUM_REQ(2)) ifb ();

  uart_tx_arbiter #(.NUM_REQ(2), .MAX_BURST(16), .GAP_CLKS(8)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .bus(ifa.slave));
  uart_tx_arbiter #(.NUM_REQ(2), .MAX_BURST(2), .GAP_CLKS(8)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .bus(ifb.slave));

  logic [1:0]  req_dv;
  logic [15:0] req_byte;
  logic [1:0]  req_last;
  logic        tx_active, tx_done;
  logic [5:0]  tx_cnt;
  logic [1:0]  done_cnt;

  assign ifa.i_Req_DV    = sel ? 2'b00 : req_dv;
  assign ifa.i_Req_Byte  = sel ? 16'h0 : req_byte;
  assign ifa.i_Req_Last  = sel ? 2'b00 : req_last;
  assign ifb.i_Req_DV    = sel ? req_dv : 2'b00;
  assign ifb.i_Req_Byte  = sel ? req_byte : 16'h0;
  assign ifb.i_Req_Last  = sel ? req_last : 2'b00;
  assign ifa.i_TX_Active = tx_active;
  assign ifa.i_TX_Done   = tx_done;
  assign ifb.i_TX_Active = tx_active;
  assign ifb.i_TX_Done   = tx_done;

  logic [1:0] m_ack, m_grant;
  logic       m_dv, m_busy;
  logic [7:0] m_byte;
  assign m_ack   = sel ? ifb.o_Req_Ack : ifa.o_Req_Ack;
  assign m_grant = sel ? ifb.o_Grant   : ifa.o_Grant;
  assign m_dv    = sel ? ifb.o_TX_DV   : ifa.o_TX_DV;
  assign m_busy  = sel ? ifb.o_Busy    : ifa.o_Busy;
  assign m_byte  = sel ? ifb.o_TX_Byte : ifa.o_TX_Byte;

  int n_vec = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];   // {owner, byte}
  logic [8:0] rq0[$];     // {last, byte}
  logic [8:0] rq1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // UART_TX model: 40 clocks Active, then Done for 2 clocks with Active low.
  always @(posedge clk) begin
    if (m_dv) begin
      tx_active <= 1'b1;
      tx_done   <= 1'b0;
      tx_cnt    <= 6'd40;
    end else if (tx_active) begin
      if (tx_cnt == 6'd1) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
        done_cnt  <= 2'd2;
      end
      tx_cnt <= tx_cnt - 6'd1;
    end else if (tx_done) begin
      if (done_cnt == 2'd1) tx_done <= 1'b0;
      done_cnt <= done_cnt - 2'd1;
    end
  end

  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    tx_cnt    = '0;
    done_cnt  = '0;
  end

  // Requester drivers: hold the head entry until acked, then present the next.
  initial begin
    req_dv = '0; req_byte = '0; req_last = '0;
    forever begin
      @(negedge clk);
      if (m_ack[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (m_ack[1] && rq1.size() > 0) void'(rq1.pop_front());
      if (rq0.size() > 0) begin
        req_dv[0] = 1'b1; req_byte[7:0] = rq0[0][7:0]; req_last[0] = rq0[0][8];
      end else begin
        req_dv[0] = 1'b0;
      end
      if (rq1.size() > 0) begin
        req_dv[1] = 1'b1; req_byte[15:8] = rq1[0][7:0]; req_last[1] = rq1[0][8];
      end else begin
        req_dv[1] = 1'b0;
      end
    end
  end

  // Monitor: every issue pops the scoreboard; acks never appear without an issue.
  initial begin
    logic [8:0] e;
    logic [1:0] oh;
    forever begin
      @(negedge clk);
      if (m_dv === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_issue: got byte 0x%0h, expected no issue", m_byte);
        end else begin
          e  = exp_q.pop_front();
          oh = e[8] ? 2'b10 : 2'b01;
          chk("tx_byte", 32'(m_byte), 32'(e[7:0]));
          chk("req_ack", 32'(m_ack), 32'(oh));
          chk("grant_at_issue", 32'(m_grant), 32'(oh));
          chk("tx_idle_at_issue", 32'({tx_active, tx_done}), 32'(0));
        end
      end else if (m_ack !== 2'b00) begin
        n_vec++; n_bad++;
        $display("FAIL stray_ack: got 0x%0h, expected 0x0", m_ack);
      end
    end
  end

  task automatic at_pos();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    at_pos();
    rst_n = 1'b0;
    repeat (2) at_pos();
    rst_n = 1'b1;
    at_pos();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0 ||
            tx_active || tx_done || m_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout(name);
    chk({name, "_grant_idle"}, 32'(m_grant), 32'(0));
    chk({name, "_busy_idle"}, 32'(m_busy), 32'(0));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    sel   = 1'b0;
    repeat (3) at_pos();
    rst_n = 1'b1;
    at_pos();
    chk("rst_grant", 32'(m_grant), 32'(0));
    chk("rst_busy", 32'(m_busy), 32'(0));
    chk("rst_tx_dv", 32'(m_dv), 32'(0));
    chk("rst_tx_byte", 32'(m_byte), 32'(0));
    chk("rst_ack", 32'(m_ack), 32'(0));

    // Single byte: grant one cycle after DV, issue one cycle later.
    at_pos();
    rq0.push_back({1'b1, 8'h41});
    exp_q.push_back({1'b0, 8'h41});
    @(negedge clk);
    @(negedge clk);
    chk("t1_grant_c1", 32'(m_grant), 32'(2'b01));
    chk("t1_dv_c1", 32'(m_dv), 32'(0));
    @(negedge clk);
    chk("t1_dv_c2", 32'(m_dv), 32'(1));
    chk("t1_ack_c2", 32'(m_ack), 32'(2'b01));
    chk("t1_byte_c2", 32'(m_byte), 32'(8'h41));
    wait_drain("t1", 300);

    // Two single-byte streams alternate.
    do_reset();
    rq0.push_back({1'b1, 8'hA0}); rq0.push_back({1'b1, 8'hA0});
    rq1.push_back({1'b1, 8'hB1}); rq1.push_back({1'b1, 8'hB1});
    exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b1, 8'hB1});
    exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b1, 8'hB1});
    wait_drain("t2", 1000);

    // Packet lock: r1 waits for r0's whole packet.
    do_reset();
    rq0.push_back({1'b0, 8'h11}); rq0.push_back({1'b0, 8'h22}); rq0.push_back({1'b1, 8'h33});
    rq1.push_back({1'b1, 8'h99});
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h33}); exp_q.push_back({1'b1, 8'h99});
    wait_drain("t3", 1000);

    // Burst limit 2 on instance B.
    do_reset();
    sel = 1'b1;
    at_pos();
    chk("b_rst_grant", 32'(m_grant), 32'(0));
    for (int i = 1; i <= 5; i++) rq0.push_back({(i == 5), 8'(i)});
    rq1.push_back({1'b1, 8'hEE});
    exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b1, 8'hEE}); exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b0, 8'h04}); exp_q.push_back({1'b0, 8'h05});
    wait_drain("t4", 1500);
    sel = 1'b0;

    // Gap timeout: r0 stops mid-packet; released 8 cycles after re-entering SEND.
    do_reset();
    rq0.push_back({1'b0, 8'h10});
    rq1.push_back({1'b1, 8'h20});
    exp_q.push_back({1'b0, 8'h10}); exp_q.push_back({1'b1, 8'h20});
    n = 0;
    while (exp_q.size() != 1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("t5_first_ack");
    n = 0;
    while (tx_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout("t5_done");
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (m_grant !== 2'b00 && n < 40);
    chk("t5_gap_release_cycles", 32'(n), 32'(8));
    wait_drain("t5", 300);

    // Reset during WAIT_DONE while UART_TX keeps shifting.
    do_reset();
    rq0.push_back({1'b1, 8'h55});
    rq1.push_back({1'b1, 8'h66});
    exp_q.push_back({1'b0, 8'h55}); exp_q.push_back({1'b1, 8'h66});
    n = 0;
    while (exp_q.size() != 1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout("t6_first_ack");
    repeat (5) at_pos();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(m_grant), 32'(0));
    chk("t6_rst_busy", 32'(m_busy), 32'(0));
    chk("t6_rst_tx_dv", 32'(m_dv), 32'(0));
    chk("t6_rst_ack", 32'(m_ack), 32'(0));
    chk("t6_rst_tx_byte", 32'(m_byte), 32'(0));
    repeat (2) at_pos();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_regrant", 32'(m_grant), 32'(2'b10));
    chk("t6_held_dv", 32'(m_dv), 32'(0));
    wait_drain("t6", 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART_TX instance between NUM_REQ byte sources (e.g. RX loopback echo, status/message generators) using round-robin arbitration with packet locking. Each requester presents bytes with a valid/ack handshake and a last flag. The arbiter holds the grant for a whole packet, bounded by a burst limit and an inter-byte gap timeout. It sequences UART_TX so that no byte is issued while the transmitter is busy or cleaning up. It sits between the requesters and UART_TX's i_TX_DV/i_TX_Byte/o_TX_Active/o_TX_Done.

## Interface
- NUM_REQ, 2: number of requesters, legal 2..8.
- MAX_BURST, 16: max bytes per grant before forced release; 0 = unlimited.
- GAP_CLKS, 4096: cycles an owner may leave i_Req_DV low mid-packet before forced release; ≥1.

- i_Clk  in  1  single clock; all logic on rising edge.
- i_Rst_L  in  1  reset, asynchronous and active-low.
- i_Req_DV  in  NUM_REQ  per-requester byte valid.
- i_Req_Byte  in  8*NUM_REQ  byte of requester k at [8k+7:8k].
- i_Req_Last  in  NUM_REQ  byte is last of packet; sampled with byte.
- o_Req_Ack  out  NUM_REQ  one-cycle pulse: byte of requester k accepted.
- o_Grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- o_TX_DV  out  1  one-cycle pulse to UART_TX i_TX_DV.
- o_TX_Byte  out  8  to UART_TX i_TX_Byte; held until next issue.
- i_TX_Active  in  1  from UART_TX o_TX_Active.
- i_TX_Done  in  1  from UART_TX o_TX_Done.
- o_Busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, SEND, WAIT_DONE.
- IDLE: if any i_Req_DV high, grant the first requesting index at or after ptr, scanning upward with wrap; clear burst and gap counters; go SEND. Otherwise stay.
- SEND, owner DV high and i_TX_Active=0 and i_TX_Done=0: register byte into o_TX_Byte, pulse o_TX_DV and o_Req_Ack[owner], latch last flag, increment burst count, clear gap count, go WAIT_DONE.
- SEND, owner DV high but TX busy: stay; no gap counting.
- SEND, owner DV low: increment gap count; at GAP_CLKS, release without ack.
- WAIT_DONE: wait for i_TX_Done=1. Then release if latched last=1 or (MAX_BURST≠0 and burst count=MAX_BURST); else go SEND.
- Release: ptr ← (owner+1) mod NUM_REQ, o_Grant ← 0, go IDLE.
- Requester contract: hold DV/Byte/Last stable until its ack. A new byte may be presented in the ack cycle; it is not sampled until the next SEND.
- Non-owners are never acked while a grant is held. A burst-limited packet continues after re-arbitration.
- Counters: burst counter is $clog2(MAX_BURST+1) bits; gap counter is $clog2(GAP_CLKS+1) bits; both saturate and never wrap.

## Timing
- Reset (async assert, sync release): state IDLE, ptr 0, o_Grant 0, o_Req_Ack 0, o_TX_DV 0, o_TX_Byte 0x00, o_Busy 0, counters 0. Outputs go to these values immediately on assertion.
- Reset mid-byte: grant aborted, byte not acked again. After release, issue is gated by i_TX_Active/i_TX_Done, so a UART_TX still transmitting is never overrun.
- Latency: DV high in IDLE (cycle 0), TX idle → o_Grant cycle 1 → o_TX_DV/o_Req_Ack cycle 2.
- Within a packet: next o_TX_DV no earlier than the first cycle with i_TX_Done=0 and i_TX_Active=0 after Done.
- Between owners: at least one IDLE cycle.
- A released owner with DV still high competes at lowest priority.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Bench uses a UART_TX model with CLKS_PER_BIT=4 (Done high 2 cycles, Active low on first).
- NUM_REQ=2; r0 sends 0x41 last=1, TX idle → o_Grant=01 at cycle 1, o_TX_DV and o_Req_Ack=01 at cycle 2, o_TX_Byte=0x41; after Done, o_Grant=00 and o_Busy=0.
- r0 streams 0xA0 and r1 streams 0xB1, all last=1 → TX order A0,B1,A0,B1; no byte issued while i_TX_Active or i_TX_Done is high.
- r0 sends packet 11,22,33 (last on 33) while r1 holds 0x99 → order 11,22,33,99; o_Req_Ack[1] stays low until 33 completes.
- MAX_BURST=2; r0 sends a 5-byte packet 01..05, r1 sends 0xEE last=1 → order 01,02,EE,03,04,05.
- GAP_CLKS=8; r0 sends 0x10 last=0 then drops DV, r1 requests 0x20 → grant released 8 cycles after re-entering SEND; 0x20 sent; no extra ack to r0.
- Pull i_Rst_L low during WAIT_DONE → all outputs zero immediately; after release with the model still Active, no o_TX_DV until Active=0 and Done=0; then the pending request is served normally.
